// File: rtl/board_place_if.sv
// Pointer inputs and board_mem write port of the ship placement controller.
// The controller uses the slave modport; whatever drives the mouse and receives the writes uses master.
interface board_place_if;
    logic        start;
    logic [11:0] mouse_xpos;
    logic [11:0] mouse_ypos;
    logic        mouse_left;
    logic        mouse_right;
    logic [7:0]  write_addr;
    logic [1:0]  write_data;
    logic        write_enable;
    logic [3:0]  ship_idx;
    logic        done;

    modport master (
        output start, mouse_xpos, mouse_ypos, mouse_left, mouse_right,
        input  write_addr, write_data, write_enable, ship_idx, done
    );

    modport slave (
        input  start, mouse_xpos, mouse_ypos, mouse_left, mouse_right,
        output write_addr, write_data, write_enable, ship_idx, done
    );
endinterface

// File: rtl/board_place_ctl.sv
// Write-side controller for the player's board: clears the grid, maps mouse clicks to cells,
// places the fleet with bounds/overlap checks. Define BOARD_ROTATE_EN to let right-clicks rotate ships.
module board_place_ctl #(
    parameter logic [11:0] X_POS          = 12'd500,
    parameter logic [11:0] Y_POS          = 12'd200,
    parameter int          CELL_SIZE_LOG2 = 5,
    parameter int          X_SIZE         = 12,
    parameter int          Y_SIZE         = 12
) (
    input  logic         clk,
    input  logic         rst,
    board_place_if.slave bus,
    output logic [2:0]   state_o
);
    localparam int         CELLS     = X_SIZE * Y_SIZE;
    localparam int         IDX_W     = $clog2(CELLS);
    localparam logic [4:0] X_LIM     = 5'(X_SIZE);
    localparam logic [4:0] Y_LIM     = 5'(Y_SIZE);
    localparam logic [3:0] LAST_SHIP = 4'd9;

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_WAIT, S_CHECK, S_WRITE, S_NEXT, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       clr_x_q, clr_x_d, clr_y_q, clr_y_d;
    logic [3:0]       anchor_x_q, anchor_x_d, anchor_y_q, anchor_y_d;
    logic [2:0]       step_q, step_d;
    logic [3:0]       ship_idx_q, ship_idx_d;
    logic             done_q, done_d;
    logic             orient_q, orient_d;
    logic [CELLS-1:0] occ_q, occ_d;
    logic [7:0]       addr_q, addr_d;
    logic [1:0]       data_q, data_d;
    logic             we_q, we_d;

    logic [11:0] xpos_s1_q, xpos_s2_q, ypos_s1_q, ypos_s2_q;
    logic [2:0]  left_sync_q;
    logic        left_click;
    logic        right_click;

    // Bit 0 and 1 form the synchroniser, bit 2 remembers the previous synced level.
    always_ff @(posedge clk) begin
        if (rst) begin
            xpos_s1_q   <= '0;
            xpos_s2_q   <= '0;
            ypos_s1_q   <= '0;
            ypos_s2_q   <= '0;
            left_sync_q <= '0;
        end else begin
            xpos_s1_q   <= bus.mouse_xpos;
            xpos_s2_q   <= xpos_s1_q;
            ypos_s1_q   <= bus.mouse_ypos;
            ypos_s2_q   <= ypos_s1_q;
            left_sync_q <= {left_sync_q[1:0], bus.mouse_left};
        end
    end

    assign left_click = left_sync_q[1] & ~left_sync_q[2];

`ifdef BOARD_ROTATE_EN
    logic [2:0] right_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            right_sync_q <= '0;
        end else begin
            right_sync_q <= {right_sync_q[1:0], bus.mouse_right};
        end
    end

    assign right_click = right_sync_q[1] & ~right_sync_q[2];
`else
    logic unused_right;
    assign unused_right = bus.mouse_right;
    assign right_click  = 1'b0;
`endif

    logic signed [12:0] dx, dy;
    logic [11:0]        col_full, row_full;
    logic               in_grid;

    assign dx       = $signed({1'b0, xpos_s2_q}) - $signed({1'b0, X_POS});
    assign dy       = $signed({1'b0, ypos_s2_q}) - $signed({1'b0, Y_POS});
    assign col_full = dx[11:0] >> CELL_SIZE_LOG2;
    assign row_full = dy[11:0] >> CELL_SIZE_LOG2;
    assign in_grid  = !dx[12] && !dy[12] && (col_full < 12'(X_SIZE)) && (row_full < 12'(Y_SIZE));

    function automatic logic [2:0] ship_len(input logic [3:0] idx);
        case (idx)
            4'd0:             ship_len = 3'd4;
            4'd1, 4'd2:       ship_len = 3'd3;
            4'd3, 4'd4, 4'd5: ship_len = 3'd2;
            default:          ship_len = 3'd1;
        endcase
    endfunction

    // Cell currently visited by CHECK/WRITE; one bit wider so running off the edge is visible.
    logic [4:0]       cur_x, cur_y;
    logic [IDX_W-1:0] cur_idx;
    logic             cur_off, cur_busy, last_step;

    assign cur_x     = {1'b0, anchor_x_q} + (orient_q ? 5'd0 : {2'b00, step_q});
    assign cur_y     = {1'b0, anchor_y_q} + (orient_q ? {2'b00, step_q} : 5'd0);
    assign cur_off   = (cur_x >= X_LIM) || (cur_y >= Y_LIM);
    assign cur_idx   = IDX_W'(cur_y) * IDX_W'(X_SIZE) + IDX_W'(cur_x);
    assign cur_busy  = !cur_off && occ_q[cur_idx];
    assign last_step = (step_q == (ship_len(ship_idx_q) - 3'd1));

    always_comb begin
        state_d    = state_q;
        clr_x_d    = clr_x_q;
        clr_y_d    = clr_y_q;
        anchor_x_d = anchor_x_q;
        anchor_y_d = anchor_y_q;
        step_d     = step_q;
        ship_idx_d = ship_idx_q;
        done_d     = done_q;
        orient_d   = orient_q;
        occ_d      = occ_q;
        addr_d     = 8'h00;
        data_d     = 2'b00;
        we_d       = 1'b0;

        case (state_q)
            S_CLEAR: begin
                we_d   = 1'b1;
                addr_d = {clr_y_q, clr_x_q};
                if (clr_x_q == 4'(X_SIZE - 1)) begin
                    clr_x_d = 4'd0;
                    if (clr_y_q == 4'(Y_SIZE - 1)) begin
                        clr_y_d = 4'd0;
                        state_d = S_IDLE;
                    end else begin
                        clr_y_d = clr_y_q + 4'd1;
                    end
                end else begin
                    clr_x_d = clr_x_q + 4'd1;
                end
            end
            S_IDLE: begin
                if (bus.start) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (right_click) orient_d = ~orient_q;
                if (left_click && in_grid) begin
                    anchor_x_d = col_full[3:0];
                    anchor_y_d = row_full[3:0];
                    step_d     = 3'd0;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cur_off || cur_busy) begin
                    step_d  = 3'd0;
                    state_d = S_WAIT;
                end else if (last_step) begin
                    step_d  = 3'd0;
                    state_d = S_WRITE;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_WRITE: begin
                we_d           = 1'b1;
                data_d         = 2'b01;
                addr_d         = {cur_y[3:0], cur_x[3:0]};
                occ_d[cur_idx] = 1'b1;
                if (last_step) begin
                    step_d  = 3'd0;
                    state_d = S_NEXT;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            S_NEXT: begin
                // ship_idx stays at the last ship once the fleet is complete.
                if (ship_idx_q == LAST_SHIP) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    ship_idx_d = ship_idx_q + 4'd1;
                    state_d    = S_WAIT;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CLEAR;
            clr_x_q    <= '0;
            clr_y_q    <= '0;
            anchor_x_q <= '0;
            anchor_y_q <= '0;
            step_q     <= '0;
            ship_idx_q <= '0;
            done_q     <= 1'b0;
            orient_q   <= 1'b0;
            occ_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            we_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_x_q    <= clr_x_d;
            clr_y_q    <= clr_y_d;
            anchor_x_q <= anchor_x_d;
            anchor_y_q <= anchor_y_d;
            step_q     <= step_d;
            ship_idx_q <= ship_idx_d;
            done_q     <= done_d;
            orient_q   <= orient_d;
            occ_q      <= occ_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            we_q       <= we_d;
        end
    end

    assign bus.write_addr   = addr_q;
    assign bus.write_data   = data_q;
    assign bus.write_enable = we_q;
    assign bus.ship_idx     = ship_idx_q;
    assign bus.done         = done_q;
    assign state_o          = state_q;
endmodule

// File: tb/tb_board_place_ctl.sv
// Bench for board_place_ctl: directed click table, rotation, random placement against a
// cell-level fleet model, post-done clicks and reset during a ship write.
module tb_board_place_ctl;
    localparam int XP = 500;
    localparam int YP = 200;
    localparam int CS = 32;
    localparam int NX = 12;
    localparam int NY = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dut_state;

    always #5 clk = ~clk;

    board_place_if bus();

    board_place_ctl dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (dut_state)
    );

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];

    // Fleet model: which cells hold ships, how many ships are placed, current orientation.
    int lens[10] = '{4, 3, 3, 2, 2, 2, 1, 1, 1, 1};
    bit occ_m[NY][NX];
    int placed;
    bit vert;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every write the DUT issues must be the next one the model expects.
    always @(negedge clk) begin
        if (bus.write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h expected none",
                         bus.write_addr, bus.write_data);
            end else begin
                logic [9:0] e;
                e = exp_q.pop_front();
                check("write", {22'd0, bus.write_addr, bus.write_data}, {22'd0, e});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic bit pix_to_cell(input int x, input int y, output int cx, output int cy);
        int dxp;
        int dyp;
        dxp = x - XP;
        dyp = y - YP;
        cx = (dxp >= 0) ? dxp / CS : -1;
        cy = (dyp >= 0) ? dyp / CS : -1;
        return (dxp >= 0) && (dyp >= 0) && (cx < NX) && (cy < NY);
    endfunction

    function automatic bit model_fits(input int cx, input int cy);
        if (placed >= 10) return 1'b0;
        for (int k = 0; k < lens[placed]; k++) begin
            int x;
            int y;
            x = vert ? cx : cx + k;
            y = vert ? cy + k : cy;
            if (x >= NX || y >= NY) return 1'b0;
            if (occ_m[y][x]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_commit(input int cx, input int cy, input bit push);
        for (int k = 0; k < lens[placed]; k++) begin
            int x;
            int y;
            x = vert ? cx : cx + k;
            y = vert ? cy + k : cy;
            occ_m[y][x] = 1'b1;
            if (push) exp_q.push_back({4'(y), 4'(x), 2'b01});
        end
        placed++;
    endtask

    task automatic model_reset();
        for (int y = 0; y < NY; y++)
            for (int x = 0; x < NX; x++)
                occ_m[y][x] = 1'b0;
        placed = 0;
        vert   = 1'b0;
    endtask

    function automatic int exp_ship_idx();
        return (placed < 10) ? placed : 9;
    endfunction

    task automatic click(input int x, input int y);
        bus.mouse_xpos = 12'(x);
        bus.mouse_ypos = 12'(y);
        tick(3);
        bus.mouse_left = 1'b1;
        tick(3);
        bus.mouse_left = 1'b0;
        tick(16);
    endtask

    task automatic right_click();
        bus.mouse_right = 1'b1;
        tick(3);
        bus.mouse_right = 1'b0;
        tick(3);
`ifdef BOARD_ROTATE_EN
        vert = ~vert;
`endif
    endtask

    task automatic push_clear();
        for (int y = 0; y < NY; y++)
            for (int x = 0; x < NX; x++)
                exp_q.push_back({4'(y), 4'(x), 2'b00});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    typedef struct {
        int         x;
        int         y;
        int         nwr;
        logic [7:0] first;
        logic [3:0] idx_after;
    } click_vec_t;

    localparam int NV = 10;
    click_vec_t vecs[NV];

    initial begin
        vecs[0] = '{500, 200, 4, 8'h00, 4'd1};  // ship 0 at cell (0,0)
        vecs[1] = '{532, 200, 0, 8'h00, 4'd1};  // cell (1,0) overlaps ship 0
        vecs[2] = '{820, 360, 0, 8'h00, 4'd1};  // cell (10,5), len 3 runs off the right edge
        vecs[3] = '{788, 360, 3, 8'h59, 4'd2};  // cell (9,5) just fits
        vecs[4] = '{499, 200, 0, 8'h00, 4'd2};  // one pixel left of the grid
        vecs[5] = '{884, 300, 0, 8'h00, 4'd2};  // one pixel right of the grid
        vecs[6] = '{600, 199, 0, 8'h00, 4'd2};  // one pixel above the grid
        vecs[7] = '{600, 584, 0, 8'h00, 4'd2};  // one pixel below the grid
        vecs[8] = '{883, 583, 0, 8'h00, 4'd2};  // last pixel of cell (11,11), ship off-grid
        vecs[9] = '{500, 583, 3, 8'hB0, 4'd3};  // cell (0,11) bottom row

        bus.start       = 1'b0;
        bus.mouse_xpos  = '0;
        bus.mouse_ypos  = '0;
        bus.mouse_left  = 1'b0;
        bus.mouse_right = 1'b0;
        model_reset();

        rst = 1'b1;
        tick(3);
        check("rst_we", bus.write_enable, 0);
        check("rst_addr", bus.write_addr, 0);
        check("rst_data", bus.write_data, 0);
        check("rst_ship_idx", bus.ship_idx, 0);
        check("rst_done", bus.done, 0);

        push_clear();
        rst = 1'b0;
        wait_drain("clear_sweep", 300);
        tick(5);
        check("idle_quiet", bus.write_enable, 0);

        // Click while still in IDLE must be dropped.
        click(500, 200);
        check("idle_click_ignored", exp_q.size(), 0);
        check("idle_ship_idx", bus.ship_idx, 0);

        bus.start = 1'b1;
        tick(2);
        bus.start = 1'b0;

        for (int i = 0; i < NV; i++) begin
            int cx;
            int cy;
            bit in_g;
            for (int k = 0; k < vecs[i].nwr; k++)
                exp_q.push_back({vecs[i].first + 8'(k), 2'b01});
            if (vecs[i].nwr > 0) begin
                in_g = pix_to_cell(vecs[i].x, vecs[i].y, cx, cy);
                if (in_g) model_commit(cx, cy, 1'b0);
            end
            click(vecs[i].x, vecs[i].y);
            check($sformatf("vec%0d_drained", i), exp_q.size(), 0);
            check($sformatf("vec%0d_ship_idx", i), bus.ship_idx, vecs[i].idx_after);
            exp_q.delete();
        end

        // Right-click rotates only when the feature is built in; the model follows.
        right_click();
        model_commit(0, 2, 1'b1);
        click(500, 264);
        check("rot_drained", exp_q.size(), 0);
        check("rot_ship_idx", bus.ship_idx, exp_ship_idx());
        exp_q.delete();
        right_click();

        for (int it = 0; it < 80 && placed < 10; it++) begin
            int x;
            int y;
            int cx;
            int cy;
            bit ok;
            if ($urandom_range(0, 1) == 1) begin
                x = int'($urandom_range(450, 900));
                y = int'($urandom_range(150, 620));
            end else begin
                int s0;
                int fx;
                int fy;
                s0 = int'($urandom_range(0, NX * NY - 1));
                fx = 0;
                fy = 0;
                for (int s = 0; s < NX * NY; s++) begin
                    int c;
                    c = (s0 + s) % (NX * NY);
                    if (model_fits(c % NX, c / NX)) begin
                        fx = c % NX;
                        fy = c / NX;
                        break;
                    end
                end
                x = XP + fx * CS + int'($urandom_range(0, CS - 1));
                y = YP + fy * CS + int'($urandom_range(0, CS - 1));
            end
            ok = pix_to_cell(x, y, cx, cy);
            if (ok && model_fits(cx, cy)) model_commit(cx, cy, 1'b1);
            click(x, y);
            check($sformatf("rnd%0d_drained", it), exp_q.size(), 0);
            check($sformatf("rnd%0d_ship_idx", it), bus.ship_idx, exp_ship_idx());
            exp_q.delete();
        end
        check("fleet_done", bus.done, 1);

        // Fleet complete: further clicks write nothing and done holds.
        click(500, 400);
        click(820, 520);
        check("post_done_writes", exp_q.size(), 0);
        check("post_done_held", bus.done, 1);

        // Reset during the first write of a ship, then confirm the board starts over.
        rst = 1'b1;
        tick(2);
        model_reset();
        push_clear();
        rst = 1'b0;
        wait_drain("clear_sweep_2", 300);
        bus.start = 1'b1;
        tick(2);
        model_commit(0, 0, 1'b1);
        bus.mouse_xpos = 12'd500;
        bus.mouse_ypos = 12'd200;
        tick(3);
        bus.mouse_left = 1'b1;
        begin
            int n;
            bit seen;
            n = 0;
            seen = 1'b0;
            while (!seen && n < 40) begin
                tick(1);
                n++;
                if (bus.write_enable === 1'b1) seen = 1'b1;
            end
            check("midwrite_seen", seen, 1);
        end
        rst = 1'b1;
        bus.mouse_left = 1'b0;
        tick(1);
        check("midwrite_we_low", bus.write_enable, 0);
        exp_q.delete();
        model_reset();
        push_clear();
        tick(2);
        rst = 1'b0;
        wait_drain("clear_sweep_3", 300);
        check("after_rst_ship_idx", bus.ship_idx, 0);
        check("after_rst_done", bus.done, 0);

        model_commit(0, 0, 1'b1);
        click(500, 200);
        check("after_rst_place", exp_q.size(), 0);
        check("after_rst_ship_idx1", bus.ship_idx, exp_ship_idx());
        exp_q.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
